// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory-port arbiter: FSM state encoding and
// requester owner IDs. Kept separate so additional requester ports can reuse them.
package mem_arbiter_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GNT_I = 2'd1;
    localparam logic [1:0] ST_GNT_D = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        GNT_I = ST_GNT_I,
        GNT_D = ST_GNT_D
    } state_t;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the icache miss port, the dcache memory port and the external
// memory port. The arbiter uses the slave view; the surrounding system
// (caches plus memory) uses the master view.
interface mem_arbiter_if #(
    parameter int A_WIDTH = 32
);
    // icache miss port (read-only)
    logic [A_WIDTH-1:0] i_a;
    logic               i_strobe;
    logic [31:0]        i_din;
    logic               i_ready;

    // dcache memory port (read/write)
    logic [A_WIDTH-1:0] d_a;
    logic [31:0]        d_dout;
    logic               d_rw;
    logic               d_strobe;
    logic [31:0]        d_din;
    logic               d_ready;

    // external memory port
    logic [A_WIDTH-1:0] m_a;
    logic [31:0]        m_din;
    logic               m_rw;
    logic               m_strobe;
    logic [31:0]        m_dout;
    logic               m_ready;

    modport slave (
        input  i_a, i_strobe,
        output i_din, i_ready,
        input  d_a, d_dout, d_rw, d_strobe,
        output d_din, d_ready,
        output m_a, m_din, m_rw, m_strobe,
        input  m_dout, m_ready
    );

    modport master (
        output i_a, i_strobe,
        input  i_din, i_ready,
        output d_a, d_dout, d_rw, d_strobe,
        input  d_din, d_ready,
        input  m_a, m_din, m_rw, m_strobe,
        output m_dout, m_ready
    );

endinterface

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for a single SRAM-style memory port. One requester
// owns the port from grant until the memory's ready pulse; request fields are
// captured at grant so the owner may change or drop them mid-transaction.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int A_WIDTH = 32,
    parameter bit PRIO_D  = 1'b0
) (
    input logic         clk,
    input logic         rst,
    mem_arbiter_if.slave bus
);

    state_t             state;
    state_t             state_nxt;
    logic               last;
    logic [A_WIDTH-1:0] m_a_q;
    logic [31:0]        m_din_q;
    logic               m_rw_q;
    logic               i_ready_c;
    logic               d_ready_c;

    // Pick the next owner from the IDLE state. On a tie the data port wins
    // when PRIO_D is set; otherwise the port that did not go last is chosen,
    // which yields strict alternation under continuous contention.
    function automatic state_t arbitrate(input logic i_req, input logic d_req,
                                         input logic last_own);
        state_t pick;
        pick = IDLE;
        if (i_req && d_req) begin
            if (PRIO_D)
                pick = GNT_D;
            else
                pick = (last_own == OWN_D) ? GNT_I : GNT_D;
        end else if (i_req) begin
            pick = GNT_I;
        end else if (d_req) begin
            pick = GNT_D;
        end
        return pick;
    endfunction

    // State register; reset abandons any in-flight memory cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next state and the combinational ready pulse back to the owner.
    always_comb begin
        state_nxt = state;
        i_ready_c = 1'b0;
        d_ready_c = 1'b0;
        case (state)
            IDLE: begin
                state_nxt = arbitrate(bus.i_strobe, bus.d_strobe, last);
            end
            GNT_I: begin
                if (bus.m_ready) begin
                    i_ready_c = 1'b1;
                    state_nxt = IDLE;
                end
            end
            GNT_D: begin
                if (bus.m_ready) begin
                    d_ready_c = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Capture the winner's request fields and remember it as last owner.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_a_q   <= '0;
            m_din_q <= '0;
            m_rw_q  <= 1'b0;
            last    <= OWN_D;
        end else if (state == IDLE) begin
            if (state_nxt == GNT_I) begin
                m_a_q   <= bus.i_a;
                m_din_q <= '0;
                m_rw_q  <= 1'b0;
                last    <= OWN_I;
            end else if (state_nxt == GNT_D) begin
                m_a_q   <= bus.d_a;
                m_din_q <= bus.d_dout;
                m_rw_q  <= bus.d_rw;
                last    <= OWN_D;
            end
        end
    end

    assign bus.m_a      = m_a_q;
    assign bus.m_din    = m_din_q;
    assign bus.m_rw     = m_rw_q;
    assign bus.m_strobe = (state != IDLE);

    // Read data is shared; only the ready pulse tells a requester it is theirs.
    assign bus.i_din    = bus.m_dout;
    assign bus.d_din    = bus.m_dout;
    assign bus.i_ready  = i_ready_c;
    assign bus.d_ready  = d_ready_c;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter. Two instances run side by side,
// one round-robin and one with data priority. A transaction-level model in the
// stimulus process decides grants and completions and queues the expected memory
// request and ready pulse; a monitor per instance pops and compares.
module tb_mem_arbiter;

    localparam int AW = 32;

    logic clk = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    task automatic check(input int e, input string name,
                         input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL env%0d %s: got %0h expected %0h at %0t", e, name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [AW-1:0] a;
        logic [31:0]   din;
        logic          rw;
    } gnt_t;

    typedef struct packed {
        logic        own;
        logic [31:0] data;
    } rdy_t;

    for (genvar g = 0; g < 2; g++) begin : env
        localparam bit PRIO = (g == 1);

        mem_arbiter_if #(.A_WIDTH(AW)) bus ();
        logic rst;

        mem_arbiter #(.A_WIDTH(AW), .PRIO_D(PRIO)) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );

        gnt_t gnt_q[$];
        rdy_t rdy_q[$];
        logic busy = 1'b0;   // model: a requester owns the memory port
        logic own  = 1'b1;   // model: current owner, 1 = data port
        logic last = 1'b1;   // model: most recent owner
        bit   done = 1'b0;
        bit   fin  = 1'b0;

        // Stimulus plus transaction-level reference model.
        initial begin : drive
            int wait_cnt;
            int n_done;
            bit i_fin, d_fin, rst_done, granted_now;
            wait_cnt = 0; n_done = 0; rst_done = 0;
            rst = 1'b1;
            bus.i_a = '0; bus.i_strobe = 1'b0;
            bus.d_a = '0; bus.d_dout = '0; bus.d_rw = 1'b0; bus.d_strobe = 1'b0;
            bus.m_dout = '0; bus.m_ready = 1'b0;
            repeat (3) @(posedge clk);
            #1 rst = 1'b0;
            // Opening contention: both ports hold fixed requests high.
            bus.i_a = 32'h0000_0100; bus.i_strobe = 1'b1;
            bus.d_a = 32'h0000_2004; bus.d_dout = 32'hCAFE_F00D; bus.d_rw = 1'b1;
            bus.d_strobe = 1'b1;
            for (int c = 0; c < 3000; c++) begin
                @(posedge clk);
                i_fin = 0; d_fin = 0; granted_now = 0;
                if (!rst) begin
                    if (busy) begin
                        if (bus.m_ready) begin
                            busy = 1'b0;
                            if (own) d_fin = 1; else i_fin = 1;
                            n_done++;
                        end
                    end else if (bus.i_strobe || bus.d_strobe) begin
                        if (bus.i_strobe && bus.d_strobe)
                            own = PRIO ? 1'b1 : ~last;
                        else
                            own = bus.d_strobe;
                        last = own;
                        busy = 1'b1;
                        granted_now = 1;
                        if (own) gnt_q.push_back('{bus.d_a, bus.d_dout, bus.d_rw});
                        else     gnt_q.push_back('{bus.i_a, 32'h0, 1'b0});
                        wait_cnt = (n_done < 4) ? 3 : int'($urandom_range(0, 3));
                    end
                end
                #1;
                if (rst) begin
                    rst = 1'b0;
                end else if (n_done >= 8 && !rst_done && busy && own && !granted_now
                             && wait_cnt > 0) begin
                    // Reset while the data port waits on memory, then force a tie.
                    rst = 1'b1;
                    rst_done = 1;
                    busy = 1'b0;
                    last = 1'b1;
                    wait_cnt = 0;
                    bus.m_ready = 1'b0;
                    bus.i_strobe = 1'b1; bus.i_a = $urandom;
                    bus.d_strobe = 1'b1; bus.d_a = $urandom;
                    bus.d_dout = $urandom; bus.d_rw = 1'($urandom_range(0, 1));
                end else begin
                    if (n_done >= 4) begin
                        if (!bus.i_strobe) begin
                            if ($urandom_range(0, 2) == 0) begin
                                bus.i_strobe = 1'b1; bus.i_a = $urandom;
                            end
                        end else if (i_fin) begin
                            if ($urandom_range(0, 1) == 0) bus.i_a = $urandom;
                            else bus.i_strobe = 1'b0;
                        end else if ($urandom_range(0, 15) == 0) begin
                            bus.i_strobe = 1'b0;
                        end else if ($urandom_range(0, 7) == 0) begin
                            bus.i_a = $urandom;
                        end
                        if (!bus.d_strobe) begin
                            if ($urandom_range(0, 2) == 0) begin
                                bus.d_strobe = 1'b1; bus.d_a = $urandom;
                                bus.d_dout = $urandom; bus.d_rw = 1'($urandom_range(0, 1));
                            end
                        end else if (d_fin) begin
                            if ($urandom_range(0, 1) == 0) begin
                                bus.d_a = $urandom; bus.d_dout = $urandom;
                                bus.d_rw = 1'($urandom_range(0, 1));
                            end else begin
                                bus.d_strobe = 1'b0;
                            end
                        end else if ($urandom_range(0, 15) == 0) begin
                            bus.d_strobe = 1'b0;
                        end else if ($urandom_range(0, 7) == 0) begin
                            bus.d_a = 32'h0000_3000;
                        end
                    end
                    if (c >= 2950) begin
                        bus.i_strobe = 1'b0;
                        bus.d_strobe = 1'b0;
                    end
                    bus.m_dout = $urandom;
                    bus.m_ready = 1'b0;
                    if (busy) begin
                        if (wait_cnt == 0) begin
                            bus.m_ready = 1'b1;
                            rdy_q.push_back('{own, bus.m_dout});
                        end else begin
                            wait_cnt--;
                        end
                    end else if ($urandom_range(0, 7) == 0) begin
                        bus.m_ready = 1'b1;
                    end
                end
            end
            @(posedge clk);
            done = 1'b1;
        end

        // Monitor: compare DUT outputs against the queued expectations.
        initial begin : monitor
            logic prev;
            gnt_t cur;
            rdy_t r;
            logic [1:0] exp_rdy;
            prev = 1'b0;
            cur = '0;
            forever begin
                @(negedge clk);
                if (done) break;
                if (rst) begin
                    check(g, "rst_m_strobe", 64'(bus.m_strobe), 64'(0));
                    check(g, "rst_m_a", 64'(bus.m_a), 64'(0));
                    check(g, "rst_m_din", 64'(bus.m_din), 64'(0));
                    check(g, "rst_m_rw", 64'(bus.m_rw), 64'(0));
                    check(g, "rst_ready", 64'({bus.i_ready, bus.d_ready}), 64'(0));
                    prev = 1'b0;
                end else begin
                    check(g, "m_strobe", 64'(bus.m_strobe), 64'(busy));
                    if (bus.m_strobe && !prev) begin
                        if (gnt_q.size() == 0)
                            check(g, "grant_unexpected", 64'(bus.m_a), 64'(0) - 64'(1));
                        else
                            cur = gnt_q.pop_front();
                    end
                    if (bus.m_strobe) begin
                        check(g, "m_a", 64'(bus.m_a), 64'(cur.a));
                        check(g, "m_din", 64'(bus.m_din), 64'(cur.din));
                        check(g, "m_rw", 64'(bus.m_rw), 64'(cur.rw));
                    end
                    exp_rdy = 2'b00;
                    r = '0;
                    if (rdy_q.size() > 0) begin
                        r = rdy_q.pop_front();
                        exp_rdy = r.own ? 2'b01 : 2'b10;
                    end
                    check(g, "ready_i_d", 64'({bus.i_ready, bus.d_ready}), 64'(exp_rdy));
                    if (exp_rdy[1]) check(g, "i_din", 64'(bus.i_din), 64'(r.data));
                    if (exp_rdy[0]) check(g, "d_din", 64'(bus.d_din), 64'(r.data));
                    prev = bus.m_strobe;
                end
            end
            check(g, "grants_left", 64'(gnt_q.size()), 64'(0));
            check(g, "readies_left", 64'(rdy_q.size()), 64'(0));
            fin = 1'b1;
        end
    end

    initial begin
        wait (env[0].fin && env[1].fin);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, vectors %0d miscompares %0d",
                 vectors, miscompares);
        $fatal(1, "watchdog expired");
    end

endmodule
